clk_pattern_gen: RTL and testbench

CLK_PATTERN_GEN -- requirements
Module: clk_pattern_gen

---
 rtl/clk_pattern_gen.sv | 172 +++++++++++++++++
 tb/tb_clk_pattern_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : clk_pattern_gen
//  Purpose  : Programmable clock-pattern generator. After a start request it
//             waits phase_cyc cycles, then repeats periods of ton_cyc high and
//             toff_cyc low cycles until stopped. ton/toff are re-sampled at the
//             end of every period; an invalid (zero) value is rejected.
//  Ports    : clk, rst (sync, active-high), start, stop,
//             phase_cyc/ton_cyc/toff_cyc [CNT_W-1:0] configuration,
//             clk_out (flop output), busy, period_tick, cfg_err,
//             period_cnt [31:0] (only with CLK_PATTERN_GEN_PERIOD_COUNT_EN).
//  Options  : `define CLK_PATTERN_GEN_PERIOD_COUNT_EN adds the saturating
//             period counter output period_cnt.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_pattern_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] phase_cyc,
    input  logic [CNT_W-1:0] ton_cyc,
    input  logic [CNT_W-1:0] toff_cyc,
    output logic             clk_out,
    output logic             busy,
    output logic             period_tick,
    output logic             cfg_err
`ifdef CLK_PATTERN_GEN_PERIOD_COUNT_EN
    ,
    output logic [31:0]      period_cnt
`endif
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PHASE = 2'd1;
    localparam logic [1:0] c_ST_HIGH  = 2'd2;
    localparam logic [1:0] c_ST_LOW   = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;       // cycles remaining in current state, minus one
    logic [CNT_W-1:0] r_ton_sh;
    logic [CNT_W-1:0] r_toff_sh;
    logic             r_stop_pend;
    logic             r_clk_out;
    logic             r_tick;
    logic             r_cfg_err;

    logic w_cfg_ok;
    logic w_start_acc;

    assign w_cfg_ok    = (ton_cyc != '0) && (toff_cyc != '0);
    assign w_start_acc = (r_state == c_ST_IDLE) && start && !stop && w_cfg_ok;

    // The phase delay is held only in r_cnt: it is loaded once on start and
    // never reapplied, so no separate phase shadow is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_ton_sh    <= '0;
            r_toff_sh   <= '0;
            r_stop_pend <= 1'b0;
            r_clk_out   <= 1'b0;
            r_tick      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            // clk_out lags the HIGH state by one cycle so it comes straight
            // from a flop; the tick marks the first cycle of each high phase.
            r_clk_out <= (r_state == c_ST_HIGH);
            r_tick    <= (r_state == c_ST_HIGH) && !r_clk_out;
            r_cfg_err <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    // stop has priority over start: a simultaneous request is a no-op
                    if (start && !stop) begin
                        if (w_start_acc) begin
                            r_ton_sh    <= ton_cyc;
                            r_toff_sh   <= toff_cyc;
                            r_stop_pend <= 1'b0;
                            if (phase_cyc == '0) begin
                                r_state <= c_ST_HIGH;
                                r_cnt   <= ton_cyc - CNT_W'(1);
                            end else begin
                                r_state <= c_ST_PHASE;
                                r_cnt   <= phase_cyc - CNT_W'(1);
                            end
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end

                c_ST_PHASE: begin
                    if (stop) begin
                        r_state <= c_ST_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= c_ST_HIGH;
                        r_cnt   <= r_ton_sh - CNT_W'(1);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                c_ST_HIGH: begin
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (r_cnt == '0) begin
                        r_state <= c_ST_LOW;
                        r_cnt   <= r_toff_sh - CNT_W'(1);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                c_ST_LOW: begin
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (r_cnt == '0) begin
                        if (r_stop_pend || stop) begin
                            r_state     <= c_ST_IDLE;
                            r_stop_pend <= 1'b0;
                        end else begin
                            r_state <= c_ST_HIGH;
                            // End of period: adopt new ton/toff if both valid,
                            // otherwise keep the old pair and flag the error.
                            if (w_cfg_ok) begin
                                r_ton_sh  <= ton_cyc;
                                r_toff_sh <= toff_cyc;
                                r_cnt     <= ton_cyc - CNT_W'(1);
                            end else begin
                                r_cfg_err <= 1'b1;
                                r_cnt     <= r_ton_sh - CNT_W'(1);
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign clk_out     = r_clk_out;
    assign busy        = (r_state != c_ST_IDLE);
    assign period_tick = r_tick;
    assign cfg_err     = r_cfg_err;

`ifdef CLK_PATTERN_GEN_PERIOD_COUNT_EN
    logic [31:0] r_period_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_period_cnt <= '0;
        end else if (r_tick && (r_period_cnt != 32'hFFFF_FFFF)) begin
            r_period_cnt <= r_period_cnt + 32'd1;
        end
    end

    assign period_cnt = r_period_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_pattern_gen
//  Purpose  : Directed self-checking bench for clk_pattern_gen. Inputs are
//             driven just after the falling edge and outputs are sampled at
//             the falling edge; "k" counts rising edges after the start edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clk_pattern_gen;

    localparam int CNT_W = 16;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             start     = 1'b0;
    logic             stop      = 1'b0;
    logic [CNT_W-1:0] phase_cyc = '0;
    logic [CNT_W-1:0] ton_cyc   = '0;
    logic [CNT_W-1:0] toff_cyc  = '0;
    logic             clk_out;
    logic             busy;
    logic             period_tick;
    logic             cfg_err;
`ifdef CLK_PATTERN_GEN_PERIOD_COUNT_EN
    logic [31:0]      period_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_pattern_gen #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .phase_cyc   (phase_cyc),
        .ton_cyc     (ton_cyc),
        .toff_cyc    (toff_cyc),
        .clk_out     (clk_out),
        .busy        (busy),
        .period_tick (period_tick),
        .cfg_err     (cfg_err)
`ifdef CLK_PATTERN_GEN_PERIOD_COUNT_EN
        ,
        .period_cnt  (period_cnt)
`endif
    );

    task automatic do_reset;
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents a start request for one rising edge; returns just after it.
    task automatic launch(input logic [CNT_W-1:0] ph, input logic [CNT_W-1:0] on,
                          input logic [CNT_W-1:0] off);
        phase_cyc = ph;
        ton_cyc   = on;
        toff_cyc  = off;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL reset_clk_out got %b exp 0", clk_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", period_tick); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b exp 0", cfg_err); end
`ifdef CLK_PATTERN_GEN_PERIOD_COUNT_EN
        checks++; if (period_cnt !== 32'd0) begin errors++; $display("FAIL reset_period_cnt got %0d exp 0", period_cnt); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fast_clock;
        logic e;
        launch(16'd0, 16'd1, 16'd1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fast_busy got %b exp 1", busy); end
        checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL fast_clk_k0 got %b exp 0", clk_out); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            e = (k % 2) == 1;
            checks++; if (clk_out !== e) begin errors++; $display("FAIL fast_clk k=%0d got %b exp %b", k, clk_out, e); end
            checks++; if (period_tick !== e) begin errors++; $display("FAIL fast_tick k=%0d got %b exp %b", k, period_tick, e); end
        end
`ifdef CLK_PATTERN_GEN_PERIOD_COUNT_EN
        checks++; if (period_cnt !== 32'd4) begin errors++; $display("FAIL fast_period_cnt got %0d exp 4", period_cnt); end
`endif
        do_reset();
    endtask

    task automatic test_phase_10pct;
        logic e;
        launch(16'd2, 16'd1, 16'd9);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            e = (k >= 3) && (((k - 3) % 10) == 0);
            checks++; if (clk_out !== e) begin errors++; $display("FAIL phase_clk k=%0d got %b exp %b", k, clk_out, e); end
            checks++; if (period_tick !== e) begin errors++; $display("FAIL phase_tick k=%0d got %b exp %b", k, period_tick, e); end
        end
        do_reset();
    endtask

    task automatic test_cfg_reject;
        launch(16'd0, 16'd0, 16'd5);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rej_ton_busy got %b exp 0", busy); end
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL rej_ton_cfg_err got %b exp 1", cfg_err); end
        checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL rej_ton_clk got %b exp 0", clk_out); end
        @(negedge clk);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rej_ton_pulse_len got %b exp 0", cfg_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rej_ton_busy2 got %b exp 0", busy); end
        launch(16'd0, 16'd3, 16'd0);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL rej_toff_cfg_err got %b exp 1", cfg_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rej_toff_busy got %b exp 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_start_stop_idle;
        phase_cyc = '0; ton_cyc = '0; toff_cyc = '0;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ss_idle_busy got %b exp 0", busy); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL ss_idle_cfg_err got %b exp 0", cfg_err); end
        @(negedge clk);
    endtask

    task automatic test_stop_period;
        logic eclk, ebusy;
        launch(16'd0, 16'd3, 16'd3);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            eclk  = (k <= 3);
            ebusy = (k < 6);
            checks++; if (clk_out !== eclk) begin errors++; $display("FAIL stop_clk k=%0d got %b exp %b", k, clk_out, eclk); end
            checks++; if (busy !== ebusy) begin errors++; $display("FAIL stop_busy k=%0d got %b exp %b", k, busy, ebusy); end
            stop = (k == 2);
        end
        stop = 1'b0;
        do_reset();
    endtask

    task automatic test_stop_phase;
        launch(16'd5, 16'd2, 16'd2);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_phase_busy got %b exp 0", busy); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL stop_phase_clk k=%0d got %b exp 0", k, clk_out); end
        end
    endtask

    task automatic test_reprogram;
        logic e;
        launch(16'd0, 16'd4, 16'd4);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            e = (k <= 4) || (k >= 9 && k <= 10) || (k >= 15);
            checks++; if (clk_out !== e) begin errors++; $display("FAIL reprog_clk k=%0d got %b exp %b", k, clk_out, e); end
            checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reprog_cfg_err k=%0d got %b exp 0", k, cfg_err); end
            if (k == 5) ton_cyc = 16'd2;
        end
        do_reset();
    endtask

    task automatic test_reprogram_zero;
        logic eclk, eerr;
        launch(16'd0, 16'd4, 16'd4);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            eclk = (k <= 4) || (k >= 9 && k <= 12) || (k == 17);
            eerr = (k == 8) || (k == 16);
            checks++; if (clk_out !== eclk) begin errors++; $display("FAIL rezero_clk k=%0d got %b exp %b", k, clk_out, eclk); end
            checks++; if (cfg_err !== eerr) begin errors++; $display("FAIL rezero_cfg_err k=%0d got %b exp %b", k, cfg_err, eerr); end
            if (k == 5) ton_cyc = 16'd0;
        end
        do_reset();
    endtask

    task automatic test_back_to_back;
        logic e;
        launch(16'd0, 16'd2, 16'd2);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            e = ((k - 1) % 4) < 2;
            checks++; if (clk_out !== e) begin errors++; $display("FAIL b2b_clk k=%0d got %b exp %b", k, clk_out, e); end
            checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL b2b_cfg_err k=%0d got %b exp 0", k, cfg_err); end
            // a second start while busy must change nothing
            start     = (k == 1);
            phase_cyc = (k == 1) ? 16'd7 : 16'd0;
        end
        start = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_mid;
        launch(16'd0, 16'd3, 16'd3);
        @(negedge clk);
        @(negedge clk);
        checks++; if (clk_out !== 1'b1) begin errors++; $display("FAIL rstmid_pre_clk got %b exp 1", clk_out); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL rstmid_clk got %b exp 0", clk_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL rstmid_tick got %b exp 0", period_tick); end
`ifdef CLK_PATTERN_GEN_PERIOD_COUNT_EN
        checks++; if (period_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_period_cnt got %0d exp 0", period_cnt); end
`endif
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL rstmid_after_clk k=%0d got %b exp 0", k, clk_out); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_after_busy k=%0d got %b exp 0", k, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_fast_clock();
        test_phase_10pct();
        test_cfg_reject();
        test_start_stop_idle();
        test_stop_period();
        test_stop_phase();
        test_reprogram();
        test_reprogram_zero();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
